ant_world_server: RTL and testbench
===================================

Name: ant_world_server

Overview:
- World-side counterpart of the per-ant mover. Once per game frame it serves every ant in turn:
  - reads the ant's cell and its 8 neighbours from the grid signal/sugar RAM;
  - presents surrounding_signals and onSugar, then pulses that ant's moveNow;
  - captures collecting_sugar / dropping_sugar / mouthFull and writes the world update back to the cell;
  - asserts global_writing_flag once all ants are served.
- Sits between the ant array (through an external mux driven by ant_sel) and the grid RAM.

Parameters:
- N_ANTS, 8, number of ants served per frame.
- X_bits, 7, ant X coordinate width.
- Y_bits, 7, ant Y coordinate width.
- GRID_W, 128, grid width in cells.
- GRID_H, 128, grid height in cells.
- SIGNAL_bits, 8, pheromone field width.
- SUGAR_bits, 4, sugar count field width.
- DEPOSIT, 16, pheromone added per served ant with mouthFull=1.

Ports:
- game_clk  in  1  clock
- RESET  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse; begins a frame when idle
- ant_sel  out  clog2(N_ANTS)  index of the ant being served (drives the external mux)
- ant_X  in  X_bits  X of the selected ant
- ant_Y  in  Y_bits  Y of the selected ant
- ant_mouthFull  in  1  mouthFull of the selected ant
- ant_collecting  in  1  collecting_sugar of the selected ant
- ant_dropping  in  1  dropping_sugar of the selected ant
- moveNow  out  N_ANTS  one-hot move strobe
- surrounding_signals  out  8*SIGNAL_bits  neighbour pheromones, index = dir
- onSugar  out  1  sugar count of the served cell is nonzero
- global_writing_flag  out  1  one-cycle end-of-frame pulse
- mem_addr  out  X_bits+Y_bits  cell address = {Y,X}
- mem_rd_en  out  1  read strobe; data is valid on the next cycle
- mem_rd_data  in  SUGAR_bits+SIGNAL_bits  {sugar, signal}
- mem_wr_en  out  1  write strobe
- mem_wr_data  out  SUGAR_bits+SIGNAL_bits  {sugar, signal}
- busy  out  1  frame in progress
- sugar_delivered  out  16  count of dropping events since reset

Behaviour:
- Direction offsets (dX,dY): 0=(0,-1), 1=(+1,-1), 2=(+1,0), 3=(+1,+1), 4=(0,+1), 5=(-1,+1), 6=(-1,0), 7=(-1,-1).
- Reset: state IDLE; ant_sel=0; all outputs 0, including sugar_delivered and the surrounding_signals registers.
- FSM states: IDLE, SELECT, READ, DRAIN, MOVE, WRITE, FLUSH.
- IDLE:
  - On frame_start go to SELECT with ant_sel=0 and busy=1.
  - frame_start while busy is ignored.
- SELECT (1 cycle): latch ant_X, ant_Y.
- READ (9 cycles, k=0..8):
  - k=0 issues the centre cell; k=1..8 issue neighbour dir=k-1.
  - Each cycle captures the data for k-1 into a register.
  - A neighbour outside 0..GRID_W-1 / 0..GRID_H-1 issues no read (mem_rd_en=0); its captured value is 0. No wrap-around.
- DRAIN (1 cycle): capture dir 7.
  - The centre word is held as {c_sugar, c_sig}.
  - onSugar = (c_sugar != 0).
- MOVE (1 cycle):
  - moveNow[ant_sel]=1; surrounding_signals and onSugar are stable.
  - Latch ant_collecting, ant_dropping, ant_mouthFull in this same cycle (they reflect pre-move state).
- WRITE (1 cycle):
  - mem_addr = latched centre; mem_wr_en=1.
  - sugar = c_sugar-1 if collecting and c_sugar>0, else c_sugar (saturates at 0).
  - signal = min(c_sig+DEPOSIT, 2^SIGNAL_bits-1) if the latched mouthFull=1, else c_sig.
  - On dropping, sugar_delivered increments (wraps at 2^16).
  - If ant_sel==N_ANTS-1 go to FLUSH; else increment ant_sel and go to SELECT.
- FLUSH (1 cycle): global_writing_flag=1, busy=0, ant_sel=0, then IDLE.
- Timing:
  - 13 cycles per ant; frame = 13*N_ANTS+1 cycles from the cycle after frame_start.
  - mem_rd_en and mem_wr_en are never both high.
  - moveNow is one-hot and high for exactly one cycle per ant per frame.
- RESET mid-frame:
  - Abort; no further writes or strobes.
  - global_writing_flag is not pulsed and the state returns to IDLE.

Test Plan:
- Ant 0 at (5,5), all neighbour signals 0 except dir 2 (cell (6,5)) = 40: after DRAIN, surrounding_signals[2]=40 and the others are 0; moveNow=8'b0000_0001 exactly at cycle 12 after frame_start.
- Ant at (0,0): no reads issued for dirs 0,1,5,6,7 (mem_rd_en low on those READ cycles); those fields are 0; dirs 2,3,4 are read from (1,0), (1,1), (0,1).
- Centre {sugar=3, sig=250}, collecting=1, mouthFull=1: WRITE gives mem_wr_data {2,255} (saturated); centre sugar=0 with collecting=1 writes sugar 0.
- N_ANTS=8, dropping=1 for ants 2 and 5: sugar_delivered=2; global_writing_flag high only at cycle 105; moveNow pulses at cycles 12+13i.
- frame_start reasserted at cycle 30: ignored, frame length unchanged.
- RESET at cycle 20: all outputs 0 next cycle; no global_writing_flag; a new frame_start restarts from ant 0.

Source files
------------

// File: rtl/ant_world_server_if.sv
// Ant-side mux bus and grid RAM port of the world server, bundled as one interface.
interface ant_world_server_if #(
   parameter int N_ANTS      = 8,
   parameter int X_bits      = 7,
   parameter int Y_bits      = 7,
   parameter int SIGNAL_bits = 8,
   parameter int SUGAR_bits  = 4
);
   localparam int SEL_W = (N_ANTS > 1) ? $clog2(N_ANTS) : 1;

   logic [SEL_W-1:0]                 ant_sel;
   logic [X_bits-1:0]                ant_X;
   logic [Y_bits-1:0]                ant_Y;
   logic                             ant_mouthFull;
   logic                             ant_collecting;
   logic                             ant_dropping;
   logic [N_ANTS-1:0]                moveNow;
   logic [7:0][SIGNAL_bits-1:0]      surrounding_signals;
   logic                             onSugar;
   logic [X_bits+Y_bits-1:0]         mem_addr;
   logic                             mem_rd_en;
   logic [SUGAR_bits+SIGNAL_bits-1:0] mem_rd_data;
   logic                             mem_wr_en;
   logic [SUGAR_bits+SIGNAL_bits-1:0] mem_wr_data;

   modport master (
      output ant_sel, moveNow, surrounding_signals, onSugar,
             mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
      input  ant_X, ant_Y, ant_mouthFull, ant_collecting, ant_dropping, mem_rd_data
   );

   modport slave (
      input  ant_sel, moveNow, surrounding_signals, onSugar,
             mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
      output ant_X, ant_Y, ant_mouthFull, ant_collecting, ant_dropping, mem_rd_data
   );
endinterface

// File: rtl/ant_world_server.sv
// Per-frame world server: for each ant, reads its 3x3 neighbourhood, strobes
// moveNow, then writes the sugar/pheromone update back to the centre cell.
module ant_world_server #(
   parameter int N_ANTS      = 8,
   parameter int X_bits      = 7,
   parameter int Y_bits      = 7,
   parameter int GRID_W      = 128,
   parameter int GRID_H      = 128,
   parameter int SIGNAL_bits = 8,
   parameter int SUGAR_bits  = 4,
   parameter int DEPOSIT     = 16
)(
   input  logic                 game_clk,
   input  logic                 RESET,
   input  logic                 frame_start,
   ant_world_server_if.master   bus,
   output logic                 global_writing_flag,
   output logic                 busy,
   output logic [15:0]          sugar_delivered
);
   localparam int SEL_W = (N_ANTS > 1) ? $clog2(N_ANTS) : 1;

   typedef enum logic [2:0] {IDLE, SELECT, READ, DRAIN, MOVE, WRITE, FLUSH} state_t;
   state_t state, state_nx;

   logic [SEL_W-1:0]            ant_sel;
   logic [3:0]                  k;
   logic [X_bits-1:0]           cx;
   logic [Y_bits-1:0]           cy;
   logic [SUGAR_bits-1:0]       c_sugar;
   logic [SIGNAL_bits-1:0]      c_sig;
   logic [7:0][SIGNAL_bits-1:0] nbr;
   logic                        cap_vld, cap_rd;
   logic [3:0]                  cap_idx;
   logic                        lat_coll, lat_drop, lat_mf;

   logic [2:0]                  dir;
   logic signed [1:0]           dx, dy;
   logic signed [X_bits+1:0]    nx;
   logic signed [Y_bits+1:0]    ny;
   logic                        in_grid;
   logic [SUGAR_bits-1:0]       new_sugar;
   logic [SIGNAL_bits:0]        sig_sum;
   logic [SIGNAL_bits-1:0]      new_sig;
   logic                        last_ant;

   // Neighbour coordinate for READ slot k (k=0 is the centre itself).
   always_comb begin
      dir = 3'(k - 4'd1);
      dx  = 2'sd0;
      dy  = 2'sd0;
      if (k != 4'd0) begin
         case (dir)
            3'd0: begin dx =  2'sd0; dy = -2'sd1; end
            3'd1: begin dx =  2'sd1; dy = -2'sd1; end
            3'd2: begin dx =  2'sd1; dy =  2'sd0; end
            3'd3: begin dx =  2'sd1; dy =  2'sd1; end
            3'd4: begin dx =  2'sd0; dy =  2'sd1; end
            3'd5: begin dx = -2'sd1; dy =  2'sd1; end
            3'd6: begin dx = -2'sd1; dy =  2'sd0; end
            default: begin dx = -2'sd1; dy = -2'sd1; end
         endcase
      end
      nx = $signed({2'b00, cx}) + $signed({{X_bits{dx[1]}}, dx});
      ny = $signed({2'b00, cy}) + $signed({{Y_bits{dy[1]}}, dy});
      in_grid = !nx[X_bits+1] && (nx < (X_bits+2)'(GRID_W)) &&
                !ny[Y_bits+1] && (ny < (Y_bits+2)'(GRID_H));
   end

   always_comb begin
      new_sugar = (lat_coll && c_sugar != '0) ? c_sugar - 1'b1 : c_sugar;
      sig_sum   = {1'b0, c_sig} + (SIGNAL_bits+1)'(DEPOSIT);
      new_sig   = c_sig;
      if (lat_mf)
         new_sig = sig_sum[SIGNAL_bits] ? '1 : sig_sum[SIGNAL_bits-1:0];
      last_ant  = (ant_sel == SEL_W'(N_ANTS-1));
   end

   always_ff @(posedge game_clk) begin
      if (RESET) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx            = state;
      busy                = 1'b0;
      global_writing_flag = 1'b0;
      bus.moveNow         = '0;
      bus.mem_rd_en       = 1'b0;
      bus.mem_wr_en       = 1'b0;
      bus.mem_addr        = '0;
      bus.mem_wr_data     = '0;
      case (state)
         IDLE:   if (frame_start) state_nx = SELECT;
         SELECT: begin busy = 1'b1; state_nx = READ; end
         READ: begin
            busy = 1'b1;
            if (k == 4'd0) begin
               bus.mem_rd_en = 1'b1;
               bus.mem_addr  = {cy, cx};
            end else if (in_grid) begin
               bus.mem_rd_en = 1'b1;
               bus.mem_addr  = {ny[Y_bits-1:0], nx[X_bits-1:0]};
            end
            if (k == 4'd8) state_nx = DRAIN;
         end
         DRAIN:  begin busy = 1'b1; state_nx = MOVE; end
         MOVE: begin
            busy        = 1'b1;
            bus.moveNow = N_ANTS'(1) << ant_sel;
            state_nx    = WRITE;
         end
         WRITE: begin
            busy            = 1'b1;
            bus.mem_wr_en   = 1'b1;
            bus.mem_addr    = {cy, cx};
            bus.mem_wr_data = {new_sugar, new_sig};
            state_nx        = last_ant ? FLUSH : SELECT;
         end
         FLUSH: begin global_writing_flag = 1'b1; state_nx = IDLE; end
         default: state_nx = IDLE;
      endcase
   end

   // Read data lands one cycle after its strobe; cap_* remembers which slot it belongs to.
   always_ff @(posedge game_clk) begin
      if (RESET) begin
         ant_sel         <= '0;
         k               <= '0;
         cx              <= '0;
         cy              <= '0;
         c_sugar         <= '0;
         c_sig           <= '0;
         nbr             <= '0;
         cap_vld         <= 1'b0;
         cap_rd          <= 1'b0;
         cap_idx         <= '0;
         lat_coll        <= 1'b0;
         lat_drop        <= 1'b0;
         lat_mf          <= 1'b0;
         sugar_delivered <= '0;
      end else begin
         cap_vld <= (state == READ);
         cap_rd  <= bus.mem_rd_en;
         cap_idx <= k;
         if (cap_vld) begin
            if (cap_idx == 4'd0)
               {c_sugar, c_sig} <= cap_rd ? bus.mem_rd_data : '0;
            else
               nbr[3'(cap_idx - 4'd1)] <= cap_rd ? bus.mem_rd_data[SIGNAL_bits-1:0] : '0;
         end
         case (state)
            SELECT: begin
               cx <= bus.ant_X;
               cy <= bus.ant_Y;
               k  <= '0;
            end
            READ: k <= k + 4'd1;
            MOVE: begin
               lat_coll <= bus.ant_collecting;
               lat_drop <= bus.ant_dropping;
               lat_mf   <= bus.ant_mouthFull;
            end
            WRITE: begin
               if (lat_drop) sugar_delivered <= sugar_delivered + 16'd1;
               ant_sel <= last_ant ? '0 : ant_sel + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.ant_sel             = ant_sel;
   assign bus.surrounding_signals = nbr;
   assign bus.onSugar             = (c_sugar != '0);
endmodule

// File: tb/tb_ant_world_server.sv
// Bench for ant_world_server: grid RAM model, table vectors, directed corner
// sequences and random frames against a cell-level reference of the world.
module tb_ant_world_server;
  localparam int N = 8, XB = 7, YB = 7, SB = 8, GB = 4, DEP = 16;
  localparam int GW = 128, GH = 128;
  localparam int MEMSZ = 1 << (XB + YB);

  logic game_clk = 1'b0;
  logic RESET, frame_start;
  logic global_writing_flag, busy;
  logic [15:0] sugar_delivered;

  ant_world_server_if #(.N_ANTS(N), .X_bits(XB), .Y_bits(YB), .SIGNAL_bits(SB), .SUGAR_bits(GB)) bus();

  ant_world_server #(.N_ANTS(N), .X_bits(XB), .Y_bits(YB), .GRID_W(GW), .GRID_H(GH),
                     .SIGNAL_bits(SB), .SUGAR_bits(GB), .DEPOSIT(DEP)) dut (
    .game_clk(game_clk), .RESET(RESET), .frame_start(frame_start), .bus(bus),
    .global_writing_flag(global_writing_flag), .busy(busy), .sugar_delivered(sugar_delivered));

  always #5 game_clk = ~game_clk;

  // ant array behind the external mux
  logic [XB-1:0] ax [N];
  logic [YB-1:0] ay [N];
  logic a_coll [N], a_drop [N], a_mf [N];
  assign bus.ant_X          = ax[bus.ant_sel];
  assign bus.ant_Y          = ay[bus.ant_sel];
  assign bus.ant_collecting = a_coll[bus.ant_sel];
  assign bus.ant_dropping   = a_drop[bus.ant_sel];
  assign bus.ant_mouthFull  = a_mf[bus.ant_sel];

  // grid RAM, one-cycle read latency; preload/clear ports for setup
  logic [11:0] ram [MEMSZ];
  logic clr_req, pl_en;
  logic [13:0] pl_addr;
  logic [11:0] pl_data;
  always @(posedge game_clk) begin
    if (clr_req) for (int i = 0; i < MEMSZ; i++) ram[i] <= '0;
    else if (pl_en) ram[pl_addr] <= pl_data;
    else if (bus.mem_wr_en) ram[bus.mem_addr] <= bus.mem_wr_data;
    if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_addr];
  end

  int ref_sug [MEMSZ];
  int ref_sig [MEMSZ];
  int ref_deliv;
  int checks, failures;
  int DX [8], DY [8];

  typedef struct {
    int x, y, cs, cg, n2, coll, mf;
    logic [11:0] exp_w;
    logic        exp_os;
    logic [7:0]  exp_s2;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void nb(input int x, input int y, input int d, output int ok, output int ad);
    int nx, ny;
    nx = x + DX[d];
    ny = y + DY[d];
    ok = (nx >= 0 && nx < GW && ny >= 0 && ny < GH) ? 1 : 0;
    ad = ok ? ny * (1 << XB) + nx : 0;
  endfunction

  function automatic int pick();
    case ($urandom_range(0, 2))
      0: return $urandom_range(0, 3);
      1: return $urandom_range(124, 127);
      default: return $urandom_range(60, 63);
    endcase
  endfunction

  task automatic clear_grid();
    @(negedge game_clk); clr_req = 1'b1;
    @(negedge game_clk); clr_req = 1'b0;
    for (int i = 0; i < MEMSZ; i++) begin ref_sug[i] = 0; ref_sig[i] = 0; end
  endtask

  task automatic poke(input int x, input int y, input int s, input int g);
    @(negedge game_clk);
    pl_en = 1'b1; pl_addr = 14'(y * (1 << XB) + x); pl_data = {4'(s), 8'(g)};
    @(negedge game_clk); pl_en = 1'b0;
    ref_sug[y * (1 << XB) + x] = s;
    ref_sig[y * (1 << XB) + x] = g;
  endtask

  // One frame, checked every cycle; optional extra frame_start and mid-frame reset.
  task automatic run_frame(input int extra_at, input int abort_at,
                           output logic [11:0] wd0, output logic os0, output logic [7:0] s20);
    int nc, i, p, kk, ok, ad, ci, ns, ng;
    logic [N+3:0] exp_ctrl, act_ctrl;
    logic [63:0] exp_surr;
    logic [11:0] expw;
    nc = 13 * N + 1; wd0 = '0; os0 = 1'b0; s20 = '0; ad = 0;
    @(negedge game_clk); frame_start = 1'b1;
    @(negedge game_clk); frame_start = 1'b0;
    for (int c = 1; c <= nc; c++) begin
      i = (c - 1) / 13; p = (c - 1) % 13; ci = 0;
      exp_ctrl = '0;   // {busy, flag, rd_en, wr_en, moveNow}
      if (c == nc) exp_ctrl[N+2] = 1'b1;
      else begin
        exp_ctrl[N+3] = 1'b1;
        ci = ay[i] * (1 << XB) + ax[i];
        if (p >= 1 && p <= 9) begin
          kk = p - 1;
          if (kk == 0) begin ok = 1; ad = ci; end
          else nb(ax[i], ay[i], kk - 1, ok, ad);
          exp_ctrl[N+1] = (ok != 0);
        end
        if (p == 11) exp_ctrl[i] = 1'b1;
        if (p == 12) exp_ctrl[N] = 1'b1;
      end
      act_ctrl = {busy, global_writing_flag, bus.mem_rd_en, bus.mem_wr_en, bus.moveNow};
      chk($sformatf("ctrl cycle %0d", c), act_ctrl, exp_ctrl);
      if (c < nc && p >= 1 && p <= 9 && exp_ctrl[N+1])
        chk($sformatf("rd_addr cycle %0d", c), bus.mem_addr, ad);
      if (c < nc && p == 11) begin
        for (int d = 0; d < 8; d++) begin
          nb(ax[i], ay[i], d, ok, ad);
          exp_surr[d*8 +: 8] = ok ? 8'(ref_sig[ad]) : 8'd0;
        end
        chk($sformatf("surround ant %0d", i), bus.surrounding_signals, exp_surr);
        chk($sformatf("onSugar ant %0d", i), bus.onSugar, ref_sug[ci] != 0);
        if (i == 0) begin os0 = bus.onSugar; s20 = bus.surrounding_signals[2]; end
      end
      if (c < nc && p == 12) begin
        ns = (a_coll[i] && ref_sug[ci] > 0) ? ref_sug[ci] - 1 : ref_sug[ci];
        ng = a_mf[i] ? ((ref_sig[ci] + DEP > 255) ? 255 : ref_sig[ci] + DEP) : ref_sig[ci];
        expw = {4'(ns), 8'(ng)};
        chk($sformatf("wr_addr ant %0d", i), bus.mem_addr, ci);
        chk($sformatf("wr_data ant %0d", i), bus.mem_wr_data, expw);
        if (i == 0) wd0 = bus.mem_wr_data;
        ref_sug[ci] = ns; ref_sig[ci] = ng;
        if (a_drop[i]) ref_deliv = (ref_deliv + 1) & 16'hffff;
      end
      frame_start = (c == extra_at);
      if (c == abort_at) begin
        RESET = 1'b1;
        @(negedge game_clk);
        act_ctrl = {busy, global_writing_flag, bus.mem_rd_en, bus.mem_wr_en, bus.moveNow};
        chk("abort ctrl", act_ctrl, '0);
        chk("abort ant_sel", bus.ant_sel, 0);
        chk("abort surround", bus.surrounding_signals, 0);
        chk("abort onSugar", bus.onSugar, 0);
        chk("abort delivered", sugar_delivered, 0);
        chk("abort addr/wdata", {bus.mem_addr, bus.mem_wr_data}, 0);
        RESET = 1'b0;
        ref_deliv = 0;
        return;
      end
      @(negedge game_clk);
    end
    act_ctrl = {busy, global_writing_flag, bus.mem_rd_en, bus.mem_wr_en, bus.moveNow};
    chk("idle after frame", act_ctrl, '0);
    chk("sugar_delivered", sugar_delivered, ref_deliv);
  endtask

  task automatic park_ants();
    for (int i = 0; i < N; i++) begin
      ax[i] = 7'd100; ay[i] = 7'd100; a_coll[i] = 1'b0; a_drop[i] = 1'b0; a_mf[i] = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] wd0;
    logic os0;
    logic [7:0] s20;
    int bad;
    checks = 0; failures = 0; ref_deliv = 0;
    DX = '{0, 1, 1, 1, 0, -1, -1, -1};
    DY = '{-1, -1, 0, 1, 1, 1, 0, -1};
    tbl[0] = '{5, 5, 0, 0, 40, 0, 0, 12'h000, 1'b0, 8'd40};
    tbl[1] = '{0, 0, 1, 10, 33, 0, 0, 12'h10A, 1'b1, 8'd33};
    tbl[2] = '{10, 20, 3, 250, 0, 1, 1, 12'h2FF, 1'b1, 8'd0};
    tbl[3] = '{10, 20, 0, 7, 5, 1, 0, 12'h007, 1'b0, 8'd5};
    tbl[4] = '{127, 127, 15, 255, 77, 1, 1, 12'hEFF, 1'b1, 8'd0};
    tbl[5] = '{64, 0, 2, 100, 200, 0, 1, 12'h274, 1'b1, 8'd200};
    RESET = 1'b1; frame_start = 1'b0; clr_req = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    park_ants();
    repeat (3) @(negedge game_clk);
    RESET = 1'b0;
    chk("reset ctrl", {busy, global_writing_flag, bus.mem_rd_en, bus.mem_wr_en, bus.moveNow}, 0);
    chk("reset ant_sel", bus.ant_sel, 0);
    chk("reset surround/onSugar", {bus.surrounding_signals, bus.onSugar}, 0);
    chk("reset delivered", sugar_delivered, 0);

    // table vectors on ant 0; corners carry pheromone to expose any wrap-around
    for (int v = 0; v < 6; v++) begin
      clear_grid();
      park_ants();
      poke(127, 127, 0, 99); poke(127, 0, 0, 99); poke(0, 127, 0, 99);
      ax[0] = 7'(tbl[v].x); ay[0] = 7'(tbl[v].y);
      a_coll[0] = tbl[v].coll[0]; a_mf[0] = tbl[v].mf[0];
      poke(tbl[v].x, tbl[v].y, tbl[v].cs, tbl[v].cg);
      if (tbl[v].x < GW - 1) poke(tbl[v].x + 1, tbl[v].y, 0, tbl[v].n2);
      run_frame(-1, -1, wd0, os0, s20);
      chk($sformatf("vec%0d wr_data", v), wd0, tbl[v].exp_w);
      chk($sformatf("vec%0d onSugar", v), os0, tbl[v].exp_os);
      chk($sformatf("vec%0d surround[2]", v), s20, tbl[v].exp_s2);
    end

    // reset at cycle 20, then silence, then a clean frame from ant 0
    clear_grid();
    for (int i = 0; i < N; i++) begin
      ax[i] = 7'(10 + 3 * i); ay[i] = 7'(30 + i); a_coll[i] = 1'b0; a_drop[i] = 1'b1; a_mf[i] = 1'b1;
    end
    poke(10, 30, 2, 1);
    run_frame(-1, 20, wd0, os0, s20);
    bad = 0;
    repeat (150) begin
      @(negedge game_clk);
      if ({busy, global_writing_flag, bus.mem_rd_en, bus.mem_wr_en, bus.moveNow} != '0) bad++;
    end
    chk("quiet after abort", bad, 0);
    for (int i = 0; i < N; i++) a_drop[i] = (i == 2 || i == 5);
    run_frame(-1, -1, wd0, os0, s20);
    chk("delivered ants 2,5", sugar_delivered, 2);

    // frame_start during a busy frame must not restart it
    run_frame(30, -1, wd0, os0, s20);

    // random frames over edge and interior clusters, grid carried between frames
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < N; i++) begin
        ax[i] = 7'(pick()); ay[i] = 7'(pick());
        a_coll[i] = 1'($urandom_range(0, 1)); a_drop[i] = 1'($urandom_range(0, 1));
        a_mf[i] = 1'($urandom_range(0, 1));
      end
      for (int j = 0; j < 25; j++)
        poke(pick(), pick(), $urandom_range(0, 15),
             ($urandom_range(0, 1) != 0) ? $urandom_range(230, 255) : $urandom_range(0, 255));
      run_frame(-1, -1, wd0, os0, s20);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
